// File: rtl/mvau_weight_sched.sv
// Weight-memory read sequencer for one MVAU PE: walks NF x SF folds per input vector.
// Optional build macro MVAU_WSCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module mvau_weight_sched #(
    parameter int SF           = 2,
    parameter int NF           = 2,
    parameter int NUM_VEC      = 4,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    localparam int SF_BW       = (SF > 1) ? $clog2(SF) : 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic                    out_rdy,
    output logic [SF_BW-1:0]        ibuf_addr,
    output logic                    ibuf_wen,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    w_valid,
    output logic                    w_sf_last,
    output logic                    w_nf_last,
    output logic                    busy,
    output logic                    done
`ifdef MVAU_WSCHED_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int NF_BW  = (NF > 1) ? $clog2(NF) : 1;
    localparam int VEC_BW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [SF_BW-1:0]        SF_LAST   = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_LAST   = NF_BW'(NF - 1);
    localparam logic [VEC_BW-1:0]       VEC_LAST  = VEC_BW'(NUM_VEC - 1);
    localparam logic [WMEM_ADDR_BW-1:0] WMEM_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    logic [0:0]              state_q, state_d;
    logic [SF_BW-1:0]        sf_cnt_q, sf_cnt_d;
    logic [NF_BW-1:0]        nf_cnt_q, nf_cnt_d;
    logic [VEC_BW-1:0]       vec_cnt_q, vec_cnt_d;
    logic [WMEM_ADDR_BW-1:0] wmem_addr_q, wmem_addr_d;
    logic                    w_valid_q, w_valid_d;
    logic                    w_sf_last_q, w_sf_last_d;
    logic                    w_nf_last_q, w_nf_last_d;
    logic                    done_q, done_d;
`ifdef MVAU_WSCHED_STALL_CNT_EN
    logic [31:0]             stall_cnt_q, stall_cnt_d;
`endif

    logic run_s, fold0_s, fire_s, sf_last_s, nf_last_s, vec_end_s, final_s;

    // Slot handshake: folds past the first replay from the buffer and need no stream data.
    always_comb begin
        run_s     = (state_q == ST_RUN);
        fold0_s   = (nf_cnt_q == NF_BW'(0));
        fire_s    = run_s & out_rdy & (~fold0_s | in_v);
        sf_last_s = (sf_cnt_q == SF_LAST);
        nf_last_s = (nf_cnt_q == NF_LAST);
        vec_end_s = sf_last_s & nf_last_s;
        final_s   = vec_end_s & (vec_cnt_q == VEC_LAST);
    end

    // Next-state and counter update.
    always_comb begin
        state_d     = state_q;
        sf_cnt_d    = sf_cnt_q;
        nf_cnt_d    = nf_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        wmem_addr_d = wmem_addr_q;
        w_valid_d   = fire_s;
        w_sf_last_d = fire_s & sf_last_s;
        w_nf_last_d = fire_s & nf_last_s;
        done_d      = fire_s & final_s;
`ifdef MVAU_WSCHED_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    sf_cnt_d    = '0;
                    nf_cnt_d    = '0;
                    vec_cnt_d   = '0;
                    wmem_addr_d = '0;
`ifdef MVAU_WSCHED_STALL_CNT_EN
                    stall_cnt_d = 32'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fire_s) begin
                    sf_cnt_d = sf_last_s ? SF_BW'(0) : sf_cnt_q + SF_BW'(1);
                    if (sf_last_s) begin
                        nf_cnt_d = nf_last_s ? NF_BW'(0) : nf_cnt_q + NF_BW'(1);
                    end else begin
                        nf_cnt_d = nf_cnt_q;
                    end
                    if (vec_end_s) begin
                        vec_cnt_d = final_s ? VEC_BW'(0) : vec_cnt_q + VEC_BW'(1);
                    end else begin
                        vec_cnt_d = vec_cnt_q;
                    end
                    // Weight words are laid out fold-major, so the address restarts each vector.
                    if (vec_end_s || (wmem_addr_q == WMEM_LAST)) begin
                        wmem_addr_d = WMEM_ADDR_BW'(0);
                    end else begin
                        wmem_addr_d = wmem_addr_q + WMEM_ADDR_BW'(1);
                    end
                    state_d = final_s ? ST_IDLE : ST_RUN;
                end else begin
`ifdef MVAU_WSCHED_STALL_CNT_EN
                    if (stall_cnt_q != 32'hFFFF_FFFF) begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
`endif
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            sf_cnt_q    <= '0;
            nf_cnt_q    <= '0;
            vec_cnt_q   <= '0;
            wmem_addr_q <= '0;
            w_valid_q   <= 1'b0;
            w_sf_last_q <= 1'b0;
            w_nf_last_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MVAU_WSCHED_STALL_CNT_EN
            stall_cnt_q <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            sf_cnt_q    <= sf_cnt_d;
            nf_cnt_q    <= nf_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            wmem_addr_q <= wmem_addr_d;
            w_valid_q   <= w_valid_d;
            w_sf_last_q <= w_sf_last_d;
            w_nf_last_q <= w_nf_last_d;
            done_q      <= done_d;
`ifdef MVAU_WSCHED_STALL_CNT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign in_rdy    = run_s & out_rdy & fold0_s;
    assign ibuf_wen  = fire_s & fold0_s;
    assign ibuf_addr = sf_cnt_q;
    assign wmem_addr = wmem_addr_q;
    assign w_valid   = w_valid_q;
    assign w_sf_last = w_sf_last_q;
    assign w_nf_last = w_nf_last_q;
    assign busy      = run_s;
    assign done      = done_q;
`ifdef MVAU_WSCHED_STALL_CNT_EN
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mvau_weight_sched.sv
// Bench for mvau_weight_sched: per-cycle vector tables plus a slot-flag scoreboard,
// and a hand-written sequence for a degenerate SF=1/NF=1 instance.
module tb_mvau_weight_sched;

    logic       aclk = 1'b0;
    logic       areset, start, in_v, out_rdy;
    logic       in_rdy, ibuf_wen, w_valid, w_sf_last, w_nf_last, busy, done;
    logic [0:0] ibuf_addr;
    logic [3:0] wmem_addr;
    logic       d_in_rdy, d_ibuf_wen, d_w_valid, d_w_sf_last, d_w_nf_last, d_busy, d_done;
    logic [0:0] d_ibuf_addr;
    logic [3:0] d_wmem_addr;
`ifdef MVAU_WSCHED_STALL_CNT_EN
    logic [31:0] stall_cnt, d_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    mvau_weight_sched #(.SF(2), .NF(2), .NUM_VEC(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)) dut (
        .aclk(aclk), .areset(areset), .start(start), .in_v(in_v), .in_rdy(in_rdy),
        .out_rdy(out_rdy), .ibuf_addr(ibuf_addr), .ibuf_wen(ibuf_wen), .wmem_addr(wmem_addr),
        .w_valid(w_valid), .w_sf_last(w_sf_last), .w_nf_last(w_nf_last), .busy(busy),
        .done(done)
`ifdef MVAU_WSCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mvau_weight_sched #(.SF(1), .NF(1), .NUM_VEC(3), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4)) dut_deg (
        .aclk(aclk), .areset(areset), .start(start), .in_v(in_v), .in_rdy(d_in_rdy),
        .out_rdy(out_rdy), .ibuf_addr(d_ibuf_addr), .ibuf_wen(d_ibuf_wen), .wmem_addr(d_wmem_addr),
        .w_valid(d_w_valid), .w_sf_last(d_w_sf_last), .w_nf_last(d_w_nf_last), .busy(d_busy),
        .done(d_done)
`ifdef MVAU_WSCHED_STALL_CNT_EN
        , .stall_cnt(d_stall_cnt)
`endif
    );

    // exp = {busy, in_rdy, ibuf_wen, ibuf_addr, wmem_addr[3:0], w_valid, done}
    typedef struct {
        logic       st;
        logic       iv;
        logic       ordy;
        logic       rs;
        logic       fire;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] sb[$];

    function automatic void add(input logic st, input logic iv, input logic ordy,
                                input logic rs, input logic fire, input logic [9:0] exp);
        vec_t v;
        v.st = st; v.iv = iv; v.ordy = ordy; v.rs = rs; v.fire = fire; v.exp = exp;
        tbl.push_back(v);
    endfunction

    // Uninterrupted image; an optional extra start pulse at row 'restart' must change nothing.
    function automatic void add_seq1(input int restart);
        logic [9:0] e [11];
        e = '{10'b0_0_0_0_0000_0_0, 10'b1_1_1_0_0000_0_0, 10'b1_1_1_1_0001_1_0,
              10'b1_0_0_0_0010_1_0, 10'b1_0_0_1_0011_1_0, 10'b1_1_1_0_0000_1_0,
              10'b1_1_1_1_0001_1_0, 10'b1_0_0_0_0010_1_0, 10'b1_0_0_1_0011_1_0,
              10'b0_0_0_0_0000_1_1, 10'b0_0_0_0_0000_0_0};
        for (int i = 0; i < 11; i++) begin
            add((i == 0) || (i == restart), 1'b1, 1'b1, 1'b0, (i >= 1) && (i <= 8), e[i]);
        end
    endfunction

    task automatic run_table(input string name);
        logic [9:0] got;
        logic [1:0] want_fl;
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; in_v = tbl[i].iv; out_rdy = tbl[i].ordy; areset = tbl[i].rs;
            @(negedge aclk);
            got = {busy, in_rdy, ibuf_wen, ibuf_addr, wmem_addr, w_valid, done};
            checks++;
            if (got !== tbl[i].exp) begin
                errors++;
                $display("FAIL %s row %0d outputs: got %b want %b", name, i, got, tbl[i].exp);
            end
            checks++;
            if (w_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s row %0d slot: got unexpected w_valid want none", name, i);
                end else begin
                    want_fl = sb.pop_front();
                    if ({w_sf_last, w_nf_last} !== want_fl) begin
                        errors++;
                        $display("FAIL %s row %0d flags: got %b want %b", name, i,
                                 {w_sf_last, w_nf_last}, want_fl);
                    end
                end
            end else if ({w_sf_last, w_nf_last} !== 2'b00) begin
                errors++;
                $display("FAIL %s row %0d idle flags: got %b want 00", name, i,
                         {w_sf_last, w_nf_last});
            end
            // Slot flags for SF=NF=2: sf_last at odd addresses, nf_last at addresses 2,3.
            if (tbl[i].fire) begin
                sb.push_back({tbl[i].exp[2], tbl[i].exp[3]});
            end
            @(posedge aclk);
            #1;
        end
        tbl.delete();
    endtask

    initial begin
        logic [10:0] dexp [6];
        logic [10:0] dgot;
        areset = 1'b1; start = 1'b0; in_v = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'b0_0_0_0_0000_0_0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'b0_0_0_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_0_0);
        run_table("reset");

        add_seq1(-1);
        run_table("stream");

        add_seq1(3);
        tbl[7].st = 1'b1;
        run_table("restart_ignored");

        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_1_0001_1_0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b1_0_0_0_0010_1_0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b1_0_0_0_0010_0_0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b1_0_0_0_0010_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_0_0_0_0010_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_0_0_1_0011_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_0_0000_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_1_0001_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_0_0_0_0010_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_0_0_1_0011_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_1_1);
        run_table("out_stall");
`ifdef MVAU_WSCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
        end
`endif

        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_0_0000_0_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'b1_1_0_1_0001_1_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'b1_1_0_1_0001_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_1_0001_0_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'b1_0_0_0_0010_1_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'b1_0_0_1_0011_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_0_0000_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_1_0001_1_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'b1_0_0_0_0010_1_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'b1_0_0_1_0011_1_0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_1_1);
        run_table("in_stall");

        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'b1_1_1_1_0001_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'b1_0_0_0_0010_1_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_0_0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'b0_0_0_0_0000_0_0);
        run_table("abort");
        add_seq1(-1);
        run_table("after_abort");

        // Degenerate instance: {busy, in_rdy, ibuf_wen, wmem_addr, w_valid, sf_last, nf_last, done}
        dexp = '{11'b0_0_0_0000_0_0_0_0, 11'b1_1_1_0000_0_0_0_0, 11'b1_1_1_0000_1_1_1_0,
                 11'b1_1_1_0000_1_1_1_0, 11'b0_0_0_0000_1_1_1_1, 11'b0_0_0_0000_0_0_0_0};
        for (int i = 0; i < 6; i++) begin
            start = (i == 0); in_v = 1'b1; out_rdy = 1'b1; areset = 1'b0;
            @(negedge aclk);
            dgot = {d_busy, d_in_rdy, d_ibuf_wen, d_wmem_addr, d_w_valid, d_w_sf_last,
                    d_w_nf_last, d_done};
            checks++;
            if (dgot !== dexp[i]) begin
                errors++;
                $display("FAIL degenerate row %0d: got %b want %b", i, dgot, dexp[i]);
            end
            @(posedge aclk);
            #1;
        end
        start = 1'b0;

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending slots want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
